mips_int_ctrl: RTL and testbench

MIPS_INT_CTRL -- requirements
Module: mips_int_ctrl

---
 rtl/mips_int_ctrl.sv | 124 ++++++++++++
 tb/tb_mips_int_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_int_ctrl.sv
// Four-line interrupt controller: sync, edge detect, sticky pending,
// mask, fixed priority and a REQ/SERVICE handshake with the core.
module mips_int_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  INT,
    input  logic        bus_we,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        irq_o,
    output logic [1:0]  irq_id,
    input  logic        irq_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_EOI  = 2'd3;

    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] prev_q;
    logic [3:0] edge_det;
    logic [3:0] pending_q;
    logic [3:0] pending_n;
    logic [3:0] mask_q;
    logic [3:0] enabled;
    logic [1:0] in_service_q;
    state_t     state_q;
    state_t     state_n;
    logic       wr_pend;
    logic       wr_mask;
    logic       wr_eoi;
    logic       ack_take;
    logic       unused_wdata;

    function automatic logic [1:0] prio(input logic [3:0] v);
        logic [1:0] r;
        if (v[0])      r = 2'd0;
        else if (v[1]) r = 2'd1;
        else if (v[2]) r = 2'd2;
        else           r = 2'd3;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= INT;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign enabled      = pending_q & mask_q;
    assign wr_pend      = bus_we && (bus_addr == A_PEND);
    assign wr_mask      = bus_we && (bus_addr == A_MASK);
    assign wr_eoi       = bus_we && (bus_addr == A_EOI);
    assign ack_take     = (state_q == REQ) && irq_ack;
    assign unused_wdata = ^bus_wdata[31:4];

    // New edges are OR-ed in last so they win over any clear this cycle
    always_comb begin
        pending_n = pending_q;
        if (wr_pend) pending_n = pending_n & ~bus_wdata[3:0];
        if (ack_take) pending_n[irq_id] = 1'b0;
        pending_n = pending_n | edge_det;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (|enabled) state_n = REQ;
            REQ: begin
                if (irq_ack)         state_n = SERVICE;
                else if (~|enabled)  state_n = IDLE;
            end
            SERVICE: if (wr_eoi) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            mask_q       <= '0;
            in_service_q <= '0;
            irq_o        <= 1'b0;
            irq_id       <= '0;
        end else begin
            state_q   <= state_n;
            pending_q <= pending_n;
            irq_o     <= (state_n == REQ);
            if (wr_mask) mask_q <= bus_wdata[3:0];
            // Re-picked every cycle in REQ so a higher source can preempt
            if (state_n == REQ) irq_id <= prio(enabled);
            if (ack_take) in_service_q <= irq_id;
        end
    end

    always_comb begin
        bus_rdata = '0;
        unique case (bus_addr)
            A_PEND:  bus_rdata = {28'b0, pending_q};
            A_MASK:  bus_rdata = {28'b0, mask_q};
            A_STAT:  bus_rdata = {26'b0, state_q, in_service_q, 2'b0};
            A_EOI:   bus_rdata = '0;
            default: bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Directed bench for mips_int_ctrl: latency, priority order, masking,
// preemption, W1C races, ignored strobes and reset behaviour.
module tb_mips_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  INT;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq_o;
    logic [1:0]  irq_id;
    logic        irq_ack;

    int checks;
    int failures;

    mips_int_ctrl #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .INT       (INT),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq_o     (irq_o),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        @(negedge clk);
        bus_we    = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        bus_addr = a;
        #1;
        d = bus_rdata;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic pulse_int(input logic [3:0] v);
        @(negedge clk);
        INT = v;
        @(negedge clk);
        INT = 4'h0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #2;
        checks++;
        if (irq_o !== 1'b0 || irq_id !== 2'd0) begin
            failures++;
            $display("FAIL rst_irq got=%b/%0d exp=0/0", irq_o, irq_id);
        end
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rst_pending got=%h exp=0", d);
        end
        read_reg(2'd1, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rst_mask got=%h exp=0", d);
        end
        read_reg(2'd2, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rst_status got=%h exp=0", d);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_latency();
        logic [31:0] d;
        write_reg(2'd1, 32'hF);
        pulse_int(4'b0100);
        tick(2);
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h4 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL lat_pending got=%h/%b exp=4/0", d, irq_o);
        end
        tick(1);
        read_reg(2'd2, d);
        checks++;
        if (irq_o !== 1'b1 || irq_id !== 2'd2 || d[5:4] !== 2'd1) begin
            failures++;
            $display("FAIL lat_irq got=%b/%0d/%0d exp=1/2/1",
                     irq_o, irq_id, d[5:4]);
        end
        ack_pulse();
        read_reg(2'd2, d);
        checks++;
        if (irq_o !== 1'b0 || d !== 32'h28) begin
            failures++;
            $display("FAIL lat_ack got=%b/%h exp=0/28", irq_o, d);
        end
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL lat_ack_clr got=%h exp=0", d);
        end
        write_reg(2'd3, 32'h0);
        read_reg(2'd2, d);
        checks++;
        if (d[5:4] !== 2'd0) begin
            failures++;
            $display("FAIL lat_eoi got=%0d exp=0", d[5:4]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_int(4'hF);
        n = 0;
        while (irq_o !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (irq_o !== 1'b1 || irq_id !== 2'(k)) begin
                failures++;
                $display("FAIL order_req%0d got=%b/%0d exp=1/%0d",
                         k, irq_o, irq_id, k);
            end
            ack_pulse();
            checks++;
            if (irq_o !== 1'b0) begin
                failures++;
                $display("FAIL order_ack%0d got=%b exp=0", k, irq_o);
            end
            tick(2);
            checks++;
            if (irq_o !== 1'b0) begin
                failures++;
                $display("FAIL order_nonest%0d got=%b exp=0", k, irq_o);
            end
            write_reg(2'd3, 32'h0);
            tick(1);
            checks++;
            if (irq_o !== (k < 3)) begin
                failures++;
                $display("FAIL order_b2b%0d got=%b exp=%b",
                         k, irq_o, (k < 3));
            end
        end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        write_reg(2'd1, 32'h0);
        pulse_int(4'b0010);
        tick(3);
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h2 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL mask_latch got=%h/%b exp=2/0", d, irq_o);
        end
        write_reg(2'd1, 32'h2);
        tick(1);
        checks++;
        if (irq_o !== 1'b1 || irq_id !== 2'd1) begin
            failures++;
            $display("FAIL mask_enable got=%b/%0d exp=1/1", irq_o, irq_id);
        end
        ack_pulse();
        write_reg(2'd3, 32'h0);
    endtask

    task automatic test_preempt();
        logic [31:0] d;
        write_reg(2'd1, 32'hF);
        pulse_int(4'b1000);
        tick(3);
        checks++;
        if (irq_o !== 1'b1 || irq_id !== 2'd3) begin
            failures++;
            $display("FAIL pre_req3 got=%b/%0d exp=1/3", irq_o, irq_id);
        end
        pulse_int(4'b0001);
        tick(3);
        checks++;
        if (irq_o !== 1'b1 || irq_id !== 2'd0) begin
            failures++;
            $display("FAIL pre_req0 got=%b/%0d exp=1/0", irq_o, irq_id);
        end
        write_reg(2'd0, 32'h9);
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL pre_w1c got=%h exp=0", d);
        end
        tick(1);
        read_reg(2'd2, d);
        checks++;
        if (irq_o !== 1'b0 || d[5:4] !== 2'd0) begin
            failures++;
            $display("FAIL pre_idle got=%b/%0d exp=0/0", irq_o, d[5:4]);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        write_reg(2'd1, 32'h0);
        @(negedge clk);
        INT = 4'b0100;
        @(negedge clk);
        INT = 4'h0;
        @(negedge clk);
        bus_we    = 1'b1;
        bus_addr  = 2'd0;
        bus_wdata = 32'h4;
        @(negedge clk);
        bus_we    = 1'b0;
        bus_wdata = '0;
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("FAIL w1c_race got=%h exp=4", d);
        end
        write_reg(2'd0, 32'h4);
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL w1c_clear got=%h exp=0", d);
        end
    endtask

    task automatic test_ignored();
        logic [31:0] d;
        ack_pulse();
        write_reg(2'd3, 32'h0);
        read_reg(2'd2, d);
        checks++;
        if (irq_o !== 1'b0 || d[5:4] !== 2'd0) begin
            failures++;
            $display("FAIL ign_idle got=%b/%0d exp=0/0", irq_o, d[5:4]);
        end
        write_reg(2'd1, 32'hF);
        pulse_int(4'b0010);
        tick(3);
        ack_pulse();
        pulse_int(4'b0001);
        tick(3);
        ack_pulse();
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL ign_svc_pend got=%h exp=1", d);
        end
        read_reg(2'd2, d);
        checks++;
        if (irq_o !== 1'b0 || d !== 32'h24) begin
            failures++;
            $display("FAIL ign_svc_stat got=%b/%h exp=0/24", irq_o, d);
        end
        write_reg(2'd3, 32'h0);
        tick(1);
        checks++;
        if (irq_o !== 1'b1 || irq_id !== 2'd0) begin
            failures++;
            $display("FAIL ign_rereq got=%b/%0d exp=1/0", irq_o, irq_id);
        end
        ack_pulse();
        write_reg(2'd3, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        seen;
        write_reg(2'd1, 32'hF);
        pulse_int(4'b0100);
        tick(3);
        ack_pulse();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (irq_o !== 1'b0 || irq_id !== 2'd0) begin
            failures++;
            $display("FAIL rmid_out got=%b/%0d exp=0/0", irq_o, irq_id);
        end
        read_reg(2'd2, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rmid_status got=%h exp=0", d);
        end
        read_reg(2'd1, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rmid_mask got=%h exp=0", d);
        end
        rst = 1'b1;
        write_reg(2'd1, 32'hF);
        seen = 1'b0;
        repeat (200) begin
            tick(1);
            if (irq_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rmid_quiet got=%b exp=0", seen);
        end
    endtask

    task automatic test_level_held();
        logic [31:0] d;
        @(negedge clk);
        rst = 1'b0;
        INT = 4'b1000;
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick(5);
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h8 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL lvl_first got=%h/%b exp=8/0", d, irq_o);
        end
        write_reg(2'd0, 32'h8);
        tick(5);
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL lvl_once got=%h exp=0", d);
        end
        INT = 4'h0;
        tick(4);
        INT = 4'b1000;
        tick(4);
        read_reg(2'd0, d);
        checks++;
        if (d !== 32'h8) begin
            failures++;
            $display("FAIL lvl_new_edge got=%h exp=8", d);
        end
        INT = 4'h0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        INT       = 4'h0;
        bus_we    = 1'b0;
        bus_addr  = 2'd0;
        bus_wdata = '0;
        irq_ack   = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_masked();
        test_preempt();
        test_w1c_race();
        test_ignored();
        test_reset_mid();
        test_level_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
